vga_sync_module: RTL and testbench
==================================

// Module: vga_sync_module
// PURPOSE
//   Raster timing generator for the VGA path; sits directly upstream of the pixel colour stage.
//   Free-running horizontal/vertical counters produce HSYNC/VSYNC, a Ready_Sig active-video
//   qualifier and zero-based column/row pixel addresses for the colour logic to decode.
//   Default timing is SVGA 800x600@60 Hz from a 40 MHz CLK.
// PARAMETERS
//   H_SYNC    128  HSYNC pulse width, clocks
//   H_BACK     88  horizontal back porch, clocks
//   H_ACTIVE  800  visible pixels per line
//   H_FRONT    40  horizontal front porch, clocks
//   V_SYNC      4  VSYNC pulse width, lines
//   V_BACK     23  vertical back porch, lines
//   V_ACTIVE  600  visible lines per frame
//   V_FRONT     1  vertical front porch, lines
//   SYNC_POL    0  sync active level (0 = active-low, 1 = active-high); applies to both syncs
// PORTS
//   CLK              in   1   pixel clock
//   RSTn             in   1   asynchronous, active-low reset
//   HSYNC_Sig        out  1   horizontal sync to the connector
//   VSYNC_Sig        out  1   vertical sync to the connector
//   Ready_Sig        out  1   1 = current output pixel lies in the visible area
//   Column_Addr_Sig  out  11  visible column 0..H_ACTIVE-1; 0 outside the visible area
//   Row_Addr_Sig     out  11  visible row 0..V_ACTIVE-1; 0 outside the visible area
//   Line_Start_Sig   out  1   one-clock pulse at H count 0 of every line
//   Frame_Start_Sig  out  1   one-clock pulse at H=0, V=0 of every frame
// BEHAVIOUR
//   - Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (default 1056).
//     V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT (default 628).
//   - Both totals must be <= 2048. The counters are 11 bits wide.
//   - Count_H increments every clock and wraps from H_TOTAL-1 to 0.
//   - Count_V increments only on the Count_H wrap. It wraps from V_TOTAL-1 to 0 on that same edge.
//   - Line order: sync, back porch, active, front porch (same order vertically).
//   - Decode, from counter values:
//       hs_act = Count_H < H_SYNC
//       vs_act = Count_V < V_SYNC
//       h_vis  = H_SYNC+H_BACK <= Count_H < H_SYNC+H_BACK+H_ACTIVE   (vertical analogous)
//   - Every output is a register loaded from the decode of the current counter values.
//     Outputs therefore lag the counters by exactly 1 CLK. Ready_Sig and the addresses stay mutually aligned.
//   - HSYNC_Sig = hs_act ? SYNC_POL : ~SYNC_POL.   VSYNC_Sig is the same, using vs_act.
//   - Ready_Sig = h_vis & v_vis.
//   - Column_Addr_Sig = Count_H-(H_SYNC+H_BACK) when Ready, else 0.
//     Row_Addr_Sig = Count_V-(V_SYNC+V_BACK) when Ready, else 0.
//     Both addresses are zeroed together whenever Ready_Sig = 0.
//   - Line_Start_Sig = (Count_H==0). Frame_Start_Sig = (Count_H==0 && Count_V==0).
//     Each pulse lasts exactly one CLK.
//   - Reset (asynchronous, any time including mid-line or mid-frame):
//       counters -> 0; HSYNC_Sig and VSYNC_Sig -> ~SYNC_POL (inactive);
//       Ready_Sig, both addresses, Line_Start_Sig, Frame_Start_Sig -> 0.
//   - First CLK edge after RSTn rises: outputs reflect (H=0, V=0). Both syncs go active.
//     Line_Start_Sig and Frame_Start_Sig pulse.
//   - There are no partial frames: after any reset, timing restarts at the top of a frame.
//   - There is no input handshake. Downstream samples its inputs every clock and qualifies them with Ready_Sig.
// TESTING
//   1. Release reset, default params.
//      -> Edge 1: HSYNC=0, VSYNC=0, Frame_Start=1, Line_Start=1.
//      -> HSYNC stays low for exactly 128 clocks per line. Line period is 1056 clocks.
//   2. Count clocks from release.
//      -> Ready_Sig first goes 1 at edge 1+27*1056+216 = 28729 with Column=0, Row=0.
//      -> Ready_Sig stays high for 800 clocks; Column steps 0..799 and then returns to 0 with Ready=0.
//   3. Run 2 full frames.
//      -> Frame_Start period is 663168 clocks. VSYNC is low for 4*1056 = 4224 clocks.
//      -> Ready_Sig is high for 600 lines, with Row running 0..599. There are 628 Line_Start pulses per frame.
//   4. Assert RSTn mid-active (Row=300, Column=400).
//      -> Outputs go to reset values without waiting for CLK.
//      -> After release, test 1 behaviour repeats exactly.
//   5. SYNC_POL=1, small timing (H 2/2/4/2, V 1/1/3/1).
//      -> HSYNC is high for 2 of every 10 clocks. VSYNC is high for 1 of every 6 lines.
//      -> Frame period is 60 clocks. Column runs 0..3 and Row runs 0..2.
//   6. Whole run.
//      -> Assertion: Ready_Sig==0 implies both addresses are 0.
//      -> Assertion: Ready_Sig never rises during HSYNC or VSYNC active.

Source files
------------

// File: rtl/vga_sync_module.sv
// Raster timing generator: free-running H/V counters decoded into registered syncs,
// an active-video qualifier, zero-based pixel addresses and line/frame start pulses.
module vga_sync_module #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_ACTIVE = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 23,
    parameter int V_ACTIVE = 600,
    parameter int V_FRONT  = 1,
    parameter int SYNC_POL = 0
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic        Ready_Sig,
    output logic [10:0] Column_Addr_Sig,
    output logic [10:0] Row_Addr_Sig,
    output logic        Line_Start_Sig,
    output logic        Frame_Start_Sig
);

    // Totals may reach 2048, so the decode constants carry one extra bit.
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
    localparam logic [11:0] H_VIS_BEGIN = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_VIS_END   = 12'(H_SYNC + H_BACK + H_ACTIVE);

    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
    localparam logic [11:0] V_VIS_BEGIN = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_VIS_END   = 12'(V_SYNC + V_BACK + V_ACTIVE);

    localparam logic SYNC_ON = 1'(SYNC_POL);

    logic [10:0] count_h_q, count_h_d;
    logic [10:0] count_v_q, count_v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        ready_q, ready_d;
    logic [10:0] column_q, column_d;
    logic [10:0] row_q, row_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    logic [11:0] h_ext, v_ext;
    logic        h_wrap, hs_act, vs_act, h_vis, v_vis;

    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        h_ext     = {1'b0, count_h_q};
        v_ext     = {1'b0, count_v_q};
        h_wrap    = (h_ext == H_LAST);
        count_h_d = h_wrap ? 11'd0 : count_h_q + 11'd1;
        count_v_d = count_v_q;
        if (h_wrap) begin
            count_v_d = (v_ext == V_LAST) ? 11'd0 : count_v_q + 11'd1;
        end

        hs_act = (h_ext < H_SYNC_END);
        vs_act = (v_ext < V_SYNC_END);
        h_vis  = (h_ext >= H_VIS_BEGIN) && (h_ext < H_VIS_END);
        v_vis  = (v_ext >= V_VIS_BEGIN) && (v_ext < V_VIS_END);

        hsync_d = hs_act ? SYNC_ON : ~SYNC_ON;
        vsync_d = vs_act ? SYNC_ON : ~SYNC_ON;
        ready_d = h_vis && v_vis;

        // Addresses are zeroed together outside the visible area.
        column_d = 11'd0;
        row_d    = 11'd0;
        if (ready_d) begin
            column_d = count_h_q - H_VIS_BEGIN[10:0];
            row_d    = count_v_q - V_VIS_BEGIN[10:0];
        end

        line_start_d  = (count_h_q == 11'd0);
        frame_start_d = (count_h_q == 11'd0) && (count_v_q == 11'd0);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count_h_q     <= 11'd0;
            count_v_q     <= 11'd0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            ready_q       <= 1'b0;
            column_q      <= 11'd0;
            row_q         <= 11'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            count_h_q     <= count_h_d;
            count_v_q     <= count_v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            ready_q       <= ready_d;
            column_q      <= column_d;
            row_q         <= row_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HSYNC_Sig       = hsync_q;
    assign VSYNC_Sig       = vsync_q;
    assign Ready_Sig       = ready_q;
    assign Column_Addr_Sig = column_q;
    assign Row_Addr_Sig    = row_q;
    assign Line_Start_Sig  = line_start_q;
    assign Frame_Start_Sig = frame_start_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: default SVGA timing (instance a) and a tiny active-high timing (instance b).
module tb_vga_sync_module;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;

    logic        hs_a, vs_a, rdy_a, ls_a, fs_a;
    logic [10:0] col_a, row_a;
    logic        hs_b, vs_b, rdy_b, ls_b, fs_b;
    logic [10:0] col_b, row_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Whole-run invariant violation counters.
    int addr_viol = 0;
    int rise_viol = 0;
    logic prev_rdy_a = 1'b0;
    logic prev_rdy_b = 1'b0;

    // Line-one statistics for instance a.
    int hs_low_a;

    localparam int FIRST_RDY = 1 + 27 * 1056 + 216;   // 28729
    localparam int MID_EDGE  = FIRST_RDY + 1056 + 400; // row 1, column 400

    always #5 clk = ~clk;

    vga_sync_module dut_a (
        .CLK            (clk),
        .RSTn           (rst_a_n),
        .HSYNC_Sig      (hs_a),
        .VSYNC_Sig      (vs_a),
        .Ready_Sig      (rdy_a),
        .Column_Addr_Sig(col_a),
        .Row_Addr_Sig   (row_a),
        .Line_Start_Sig (ls_a),
        .Frame_Start_Sig(fs_a)
    );

    vga_sync_module #(
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
        .SYNC_POL(1)
    ) dut_b (
        .CLK            (clk),
        .RSTn           (rst_b_n),
        .HSYNC_Sig      (hs_b),
        .VSYNC_Sig      (vs_b),
        .Ready_Sig      (rdy_b),
        .Column_Addr_Sig(col_b),
        .Row_Addr_Sig   (row_b),
        .Line_Start_Sig (ls_b),
        .Frame_Start_Sig(fs_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rdy_a && (col_a != 11'd0 || row_a != 11'd0)) addr_viol++;
        if (!rdy_b && (col_b != 11'd0 || row_b != 11'd0)) addr_viol++;
        if (rdy_a && !prev_rdy_a && (!hs_a || !vs_a)) rise_viol++;
        if (rdy_b && !prev_rdy_b && (hs_b || vs_b)) rise_viol++;
        prev_rdy_a = rdy_a;
        prev_rdy_b = rdy_b;
    end

    task automatic check_reset_a(input string tag);
        check({tag, "_hsync"}, int'(hs_a), 1);
        check({tag, "_vsync"}, int'(vs_a), 1);
        check({tag, "_ready"}, int'(rdy_a), 0);
        check({tag, "_col"}, int'(col_a), 0);
        check({tag, "_row"}, int'(row_a), 0);
        check({tag, "_line_start"}, int'(ls_a), 0);
        check({tag, "_frame_start"}, int'(fs_a), 0);
    endtask

    // Releases instance a and covers edges 1..1057 (first line plus next line start).
    task automatic first_line_a(input string tag);
        @(negedge clk) rst_a_n = 1'b1;
        @(posedge clk); #1;
        check({tag, "_e1_hsync"}, int'(hs_a), 0);
        check({tag, "_e1_vsync"}, int'(vs_a), 0);
        check({tag, "_e1_frame_start"}, int'(fs_a), 1);
        check({tag, "_e1_line_start"}, int'(ls_a), 1);
        check({tag, "_e1_ready"}, int'(rdy_a), 0);
        hs_low_a = (hs_a == 1'b0) ? 1 : 0;
        for (int e = 2; e <= 1056; e++) begin
            @(posedge clk); #1;
            if (!hs_a) hs_low_a++;
            if (ls_a) check({tag, "_spurious_line_start"}, e, 1057);
        end
        @(posedge clk); #1;
        check({tag, "_line_period"}, int'(ls_a), 1);
        check({tag, "_hsync_low_clocks"}, hs_low_a, 128);
    endtask

    initial begin
        int first_rdy = 0;
        int rdy_row0  = 0;
        int step_err  = 0;
        int ls_err    = 0;
        int fs_err    = 0;
        int vs_low    = 4;   // edges 1..4 of line 0 were seen with VSYNC low by construction
        int hs_hi_b   = 0;
        int vs_hi_b   = 0;
        int fs_cnt_b  = 0;
        int max_col_b = 0;
        int max_row_b = 0;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("a_rst");
        check("b_rst_hsync", int'(hs_b), 0);
        check("b_rst_vsync", int'(vs_b), 0);

        first_line_a("a");
        vs_low = 1057;   // VSYNC is low throughout line 0 and into line 1 at edge 1057
        for (int e = 1058; e <= MID_EDGE; e++) begin
            @(posedge clk); #1;
            if (!vs_a && e <= 6000) vs_low++;
            if (ls_a && ((e - 1) % 1056) != 0) ls_err++;
            if (!ls_a && ((e - 1) % 1056) == 0) ls_err++;
            if (fs_a) fs_err++;
            if (rdy_a && first_rdy == 0) begin
                first_rdy = e;
                check("a_first_ready_col", int'(col_a), 0);
                check("a_first_ready_row", int'(row_a), 0);
            end
            if (rdy_a && row_a == 11'd0) begin
                rdy_row0++;
                if (int'(col_a) != e - FIRST_RDY) step_err++;
            end
            if (e == FIRST_RDY + 800) begin
                check("a_after_line_ready", int'(rdy_a), 0);
                check("a_after_line_col", int'(col_a), 0);
            end
        end
        check("a_vsync_low_clocks", vs_low, 4224);
        check("a_first_ready_edge", first_rdy, FIRST_RDY);
        check("a_ready_row0_clocks", rdy_row0, 800);
        check("a_col_step_errors", step_err, 0);
        check("a_line_start_errors", ls_err, 0);
        check("a_frame_start_extra", fs_err, 0);
        check("a_mid_ready", int'(rdy_a), 1);
        check("a_mid_col", int'(col_a), 400);
        check("a_mid_row", int'(row_a), 1);

        // Asynchronous reset mid-active, well away from any clock edge.
        #1 rst_a_n = 1'b0;
        #1;
        check_reset_a("a_async");
        first_line_a("a_rerun");

        // Small active-high timing: 10 clocks/line, 6 lines/frame, three frames.
        @(negedge clk) rst_b_n = 1'b1;
        for (int e = 1; e <= 180; e++) begin
            int i, h, v, vis;
            @(posedge clk); #1;
            i   = e - 1;
            h   = i % 10;
            v   = (i / 10) % 6;
            vis = (h >= 4 && h < 8 && v >= 2 && v < 5) ? 1 : 0;
            check("b_hsync", int'(hs_b), (h < 2) ? 1 : 0);
            check("b_vsync", int'(vs_b), (v < 1) ? 1 : 0);
            check("b_ready", int'(rdy_b), vis);
            check("b_col", int'(col_b), vis ? h - 4 : 0);
            check("b_row", int'(row_b), vis ? v - 2 : 0);
            check("b_line_start", int'(ls_b), (h == 0) ? 1 : 0);
            check("b_frame_start", int'(fs_b), (i % 60 == 0) ? 1 : 0);
            if (hs_b) hs_hi_b++;
            if (vs_b) vs_hi_b++;
            if (fs_b) fs_cnt_b++;
            if (int'(col_b) > max_col_b) max_col_b = int'(col_b);
            if (int'(row_b) > max_row_b) max_row_b = int'(row_b);
        end
        check("b_hsync_high_clocks", hs_hi_b, 36);
        check("b_vsync_high_clocks", vs_hi_b, 30);
        check("b_frame_count", fs_cnt_b, 3);
        check("b_max_col", max_col_b, 3);
        check("b_max_row", max_row_b, 2);

        #2 rst_b_n = 1'b0;
        #1;
        check("b_async_hsync", int'(hs_b), 0);
        check("b_async_vsync", int'(vs_b), 0);
        check("b_async_ready", int'(rdy_b), 0);

        @(negedge clk);
        check("inv_addr_zero_when_idle", addr_viol, 0);
        check("inv_ready_rise_in_sync", rise_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
